bitmux_rr: RTL and testbench
============================

# bitmux_rr

Round-robin bit collector: the gathering counterpart of the bit demultiplexer. Num independent single-bit producers each hand one bit at a time into a private one-entry buffer through a valid/ready handshake. The block merges those bits into one registered output stream, and each output bit is tagged with its source index `s`. It sits where per-lane status or data bits must be funneled back onto one shared bit line.

## Interface
- `LogNum`, default 3: width of the source-index bus. Num = 2**LogNum lanes.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `i`  in  Num: data bit per lane.
- `iv`  in  Num: lane valid. Lane k offers `i[k]` while `iv[k]` = 1.
- `irdy`  out  Num: lane ready. `irdy[k]` = ~full[k], driven from a register only (no combinational path from any input).
- `o`  out  1: output data bit.
- `s`  out  LogNum: index of the lane that produced `o`.
- `ov`  out  1: output valid.
- `ordy`  in  1: downstream ready.

## Operation
- State:
  - per-lane `buf[k]` (1 bit) and `full[k]`;
  - round-robin pointer `ptr` (LogNum bits);
  - output register `o`/`s`/`ov`.
- Lane accept: at a rising edge with `iv[k] & irdy[k]`, set `buf[k]` <= `i[k]` and `full[k]` <= 1. A full lane accepts nothing. `irdy[k]` = 0 blocks it.
- Output slot free: `load = ~ov | ordy`.
- Grant (RR mode): pick the first k with `full[k]` = 1, searching in order ptr, ptr+1, … modulo Num. The index wraps naturally in LogNum bits.
- On `load` with a grant w:
  - `o` <= `buf[w]`, `s` <= w, `ov` <= 1;
  - `full[w]` <= 0;
  - `ptr` <= w+1 (wraps).
- On `load` with no lane full: `ov` <= 0. `o`, `s` and `ptr` hold.
- No `load` (`ov & ~ordy`): `o`, `s`, `ov`, `ptr` and all `full` bits hold. Empty lanes still accept.
- Simultaneous events:
  - A lane granted at edge t cannot accept at edge t, because `irdy` was 0.
  - `irdy[w]` rises after edge t, and the lane may accept at edge t+1.
  - Other lanes accept and the output transfers in the same cycle, independently.
- The same lane never appears twice in a row while other lanes are full.
- Reset (at any time, including mid-transfer):
  - `full` <= 0 (all buffered bits are discarded), `buf` <= 0, `ptr` <= 0;
  - `o` <= 0, `s` <= 0, `ov` <= 0;
  - `irdy` reads all-ones from the cycle after reset;
  - reset dominates any accept or load in the same cycle.

## Timing
- Latency: a bit accepted at edge t is loaded into the output at edge t+1 at the earliest (when granted and `load` = 1). It is visible on `o`/`s`/`ov` during cycle t+1.
- Output transfer completes at an edge where `ov & ordy` = 1.
- Per-lane throughput is 1 bit per 2 cycles: the buffer frees at the grant edge and refills at the next edge.
- Aggregate throughput is 1 bit per cycle when at least one lane is full.
- `o` and `s` are stable while `ov & ~ordy`.
- All outputs are registered.

## Configuration
- `BITMUX_RR_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest full index always wins. `ptr` is not implemented and search starts at 0.
  - Undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both modes.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `iv` = 8'hFF -> `ov` = 0, `o` = 0, `s` = 0 after reset; `irdy` = 8'hFF the following cycle; no bits emitted.
- Single bit, LogNum=3: `iv` = 8'h08, `i` = 8'h08 for one cycle, `ordy` = 1 -> the next cycle shows `ov` = 1, `s` = 3, `o` = 1; `irdy[3]` = 0 for exactly that cycle; then `ov` = 0.
- Burst: fill all 8 lanes with `i` = 8'hA5, then `ordy` = 1 -> `s` = 0,1,…,7 on consecutive cycles, `o` = 1,0,1,0,0,1,0,1, then `ov` = 0.
- Backpressure: `ov` = 1, `s` = 2, `ordy` = 0 for 5 cycles with lanes 4 and 6 full -> `o`/`s` unchanged and `irdy[4]` = `irdy[6]` = 0 throughout; when `ordy` = 1, `s` = 4 then 6.
- Arbitration order: grant lane 2 (so `ptr` = 3), then fill lanes 1 and 4 -> RR build emits `s` = 4 then 1; `BITMUX_RR_FIXED_PRIO_EN` build emits `s` = 1 then 4.
- Reset mid-operation: assert `rst` for one cycle with `ov` = 1 and lanes 0, 5 full -> next cycle `ov` = 0, `irdy` = 8'hFF; with no new input, no stale bit ever appears.

Source files
------------

// File: rtl/bitmux_rr.sv
// rtl/bitmux_rr.sv - round-robin bit collector; BITMUX_RR_FIXED_PRIO_EN selects fixed lowest-index priority
module bitmux_rr #(
    parameter int LogNum = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**LogNum-1:0]  i,
    input  logic [2**LogNum-1:0]  iv,
    output logic [2**LogNum-1:0]  irdy,
    output logic                  o,
    output logic [LogNum-1:0]     s,
    output logic                  ov,
    input  logic                  ordy
);
    localparam int Num = 2**LogNum;

    logic [Num-1:0]    full;
    logic [Num-1:0]    lane_bit;
    logic [Num-1:0]    accept;
    logic [Num-1:0]    release_mask;
    logic [Num-1:0]    full_nxt;
    logic [Num-1:0]    lane_bit_nxt;
    logic [LogNum-1:0] start;
    logic [LogNum-1:0] grant;
    logic              have_grant;
    logic              load;

    // Ready is the complement of the occupancy register, so it never depends on inputs.
    assign irdy = ~full;

    // The output register may take a new bit when it is empty or being drained.
    assign load = ~ov | ordy;

    // A lane takes a bit only while its one-entry buffer is empty.
    assign accept = iv & ~full;

`ifdef BITMUX_RR_FIXED_PRIO_EN
    // Fixed priority: search always begins at lane 0.
    assign start = '0;
`else
    logic [LogNum-1:0] ptr;

    assign start = ptr;

    // Pointer moves just past the lane that was granted, wrapping in LogNum bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && have_grant) begin
            ptr <= grant + 1'b1;
        end
    end
`endif

    // Search full lanes starting at 'start', wrapping modulo Num; first hit wins.
    always_comb begin
        have_grant = 1'b0;
        grant      = '0;
        for (int n = 0; n < Num; n++) begin
            logic [LogNum-1:0] idx;
            idx = start + LogNum'(n);
            if (!have_grant && full[idx]) begin
                have_grant = 1'b1;
                grant      = idx;
            end
        end
    end

    // Next-state of lane buffers: fill accepted lanes, empty the lane moved to the output.
    always_comb begin
        release_mask = '0;
        if (load && have_grant) begin
            release_mask[grant] = 1'b1;
        end
        full_nxt     = (full | accept) & ~release_mask;
        lane_bit_nxt = (lane_bit & ~accept) | (i & accept);
    end

    // Lane buffer and occupancy registers; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            lane_bit <= '0;
        end else begin
            full     <= full_nxt;
            lane_bit <= lane_bit_nxt;
        end
    end

    // Output register: load the granted lane, go idle when nothing is buffered, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            o  <= 1'b0;
            s  <= '0;
            ov <= 1'b0;
        end else if (load) begin
            if (have_grant) begin
                o  <= lane_bit[grant];
                s  <= grant;
                ov <= 1'b1;
            end else begin
                ov <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitmux_rr.sv
// tb/tb_bitmux_rr.sv - scoreboard bench for bitmux_rr with directed vectors
module tb_bitmux_rr;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i;
    logic [7:0] iv;
    logic [7:0] irdy;
    logic       o;
    logic [2:0] s;
    logic       ov;
    logic       ordy;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    bitmux_rr #(.LogNum(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .i    (i),
        .iv   (iv),
        .irdy (irdy),
        .o    (o),
        .s    (s),
        .ov   (ov),
        .ordy (ordy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every completed output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && ov === 1'b1 && ordy === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got o=%0b s=%0d expected nothing", o, s);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({o, s} !== e) begin
                    bad++;
                    $display("FAIL out_bit: got o=%0b s=%0d expected o=%0b s=%0d", o, s, e[3], e[2:0]);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        i    = 8'hFF;
        iv   = 8'hFF;
        ordy = 1'b1;

        // Reset held two cycles with every lane offering.
        tick();
        tick();
        rst = 1'b0;
        iv  = 8'h00;
        i   = 8'h00;
        check("rst_ov", {7'd0, ov}, 8'h00);
        check("rst_o", {7'd0, o}, 8'h00);
        check("rst_s", {5'd0, s}, 8'h00);
        check("rst_irdy", irdy, 8'hFF);
        tick();
        check("rst_ov_after", {7'd0, ov}, 8'h00);
        check("rst_irdy_after", irdy, 8'hFF);

        // Single bit on lane 3.
        exp_q.push_back({1'b1, 3'd3});
        iv = 8'h08;
        i  = 8'h08;
        tick();
        iv = 8'h00;
        i  = 8'h00;
        check("single_irdy_busy", irdy, 8'hF7);
        check("single_ov_pre", {7'd0, ov}, 8'h00);
        tick();
        check("single_ov", {7'd0, ov}, 8'h01);
        check("single_s", {5'd0, s}, 8'h03);
        check("single_o", {7'd0, o}, 8'h01);
        check("single_irdy_free", irdy, 8'hFF);
        tick();
        check("single_ov_end", {7'd0, ov}, 8'h00);

        // Burst: all lanes full with A5, drained in order 0..7.
        do_reset();
        ordy = 1'b0;
        iv   = 8'hFF;
        i    = 8'hA5;
        tick();
        iv = 8'h00;
        i  = 8'h00;
        check("burst_irdy_full", irdy, 8'h00);
        tick();
        check("burst_first_s", {5'd0, s}, 8'h00);
        check("burst_first_ov", {7'd0, ov}, 8'h01);
        begin
            logic [7:0] pat;
            pat = 8'hA5;
            for (int k = 0; k < 8; k++) exp_q.push_back({pat[k], 3'(k)});
        end
        ordy = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("burst_ov_end", {7'd0, ov}, 8'h00);

        // Backpressure with lane 2 on the output and lanes 4, 6 waiting.
        do_reset();
        ordy = 1'b0;
        iv   = 8'h04;
        i    = 8'h04;
        tick();
        iv = 8'h00;
        i  = 8'h00;
        tick();
        iv = 8'h50;
        i  = 8'h40;
        tick();
        iv = 8'h00;
        i  = 8'h00;
        exp_q.push_back({1'b1, 3'd2});
        exp_q.push_back({1'b0, 3'd4});
        exp_q.push_back({1'b1, 3'd6});
        for (int c = 0; c < 5; c++) begin
            check("bp_ov", {7'd0, ov}, 8'h01);
            check("bp_s", {5'd0, s}, 8'h02);
            check("bp_o", {7'd0, o}, 8'h01);
            check("bp_irdy", irdy, 8'hAF);
            tick();
        end
        ordy = 1'b1;
        tick();
        tick();
        tick();
        check("bp_ov_end", {7'd0, ov}, 8'h00);
        check("bp_irdy_end", irdy, 8'hFF);

        // Arbitration: grant lane 2, then lanes 1 and 4 compete.
        do_reset();
        ordy = 1'b1;
        iv   = 8'h04;
        i    = 8'h00;
        exp_q.push_back({1'b0, 3'd2});
        tick();
        iv = 8'h00;
        tick();
        iv = 8'h12;
        i  = 8'h02;
        tick();
        iv = 8'h00;
        i  = 8'h00;
`ifdef BITMUX_RR_FIXED_PRIO_EN
        exp_q.push_back({1'b1, 3'd1});
        exp_q.push_back({1'b0, 3'd4});
`else
        exp_q.push_back({1'b0, 3'd4});
        exp_q.push_back({1'b1, 3'd1});
`endif
        tick();
`ifdef BITMUX_RR_FIXED_PRIO_EN
        check("arb_first_s", {5'd0, s}, 8'h01);
`else
        check("arb_first_s", {5'd0, s}, 8'h04);
`endif
        tick();
        tick();
        check("arb_ov_end", {7'd0, ov}, 8'h00);

        // Reset while a bit is on the output and lanes 0, 5 are full.
        ordy = 1'b0;
        iv   = 8'h08;
        i    = 8'h08;
        tick();
        iv = 8'h00;
        tick();
        iv = 8'h21;
        i  = 8'h21;
        tick();
        iv = 8'h00;
        i  = 8'h00;
        check("mid_ov_before", {7'd0, ov}, 8'h01);
        check("mid_irdy_before", irdy, 8'hDE);
        do_reset();
        check("mid_ov_after", {7'd0, ov}, 8'h00);
        check("mid_irdy_after", irdy, 8'hFF);
        ordy = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("mid_no_stale_ov", {7'd0, ov}, 8'h00);
        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
